// File: rtl/sram_responder_pkg.sv
// Shared types, default widths and sizing helpers for the SRAM responder.
package sram_responder_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned RD_WAIT_DEF = 2;
  localparam int unsigned WR_WAIT_DEF = 2;
  localparam int unsigned TURN_DEF    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_TURN,
    ST_RD_STROBE
  } sram_state_t;

  // Largest of the three wait parameters.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Down-counter width able to hold any wait count.
  function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                            input int unsigned wr_wait,
                                            input int unsigned turn);
    return $clog2(max3(rd_wait, wr_wait, turn) + 1);
  endfunction

endpackage

// File: rtl/sram_responder_wait_counter.sv
// Loadable down-counter used to time SRAM strobe and turnaround phases.
module sram_wait_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/sram_responder.sv
// Executes single-word read/write requests on an asynchronous SRAM with
// programmable strobe widths and a write-to-read bus turnaround.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT = WR_WAIT_DEF,
  parameter int unsigned TURN    = TURN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_busy,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_rd_valid,
  output logic              mem_collide,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int unsigned CNT_W = cnt_width(RD_WAIT, WR_WAIT, TURN);

  if (RD_WAIT < 1) begin : g_bad_rd_wait
    $error("sram_responder: RD_WAIT must be >= 1");
  end
  if (WR_WAIT < 1) begin : g_bad_wr_wait
    $error("sram_responder: WR_WAIT must be >= 1");
  end

  sram_state_t      state;
  logic             last_wr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;
  logic             use_turn;

  // A read needs a turnaround only when the bus was last driven by a write.
  assign use_turn = last_wr && (TURN > 0);

  // Counter control: load on entry to each timed phase, count down inside it.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!mem_wr_req && mem_rd_req) begin
          cnt_load     = 1'b1;
          cnt_load_val = use_turn ? CNT_W'(TURN - 1) : CNT_W'(RD_WAIT - 1);
        end
      end
      ST_WR_SETUP: begin
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(WR_WAIT - 1);
      end
      ST_WR_PULSE: cnt_en = 1'b1;
      ST_RD_TURN: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(RD_WAIT - 1);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RD_STROBE: cnt_en = 1'b1;
      default: ;
    endcase
  end

  sram_wait_counter #(.W(CNT_W)) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero_c   (cnt_zero)
  );

  // Access sequencer; every SRAM pin and status output is set on state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_wr      <= 1'b0;
      mem_busy     <= 1'b0;
      mem_rd_data  <= '0;
      mem_rd_valid <= 1'b0;
      mem_collide  <= 1'b0;
      sram_addr    <= '0;
      sram_dq_out  <= '0;
      sram_dq_oe   <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
    end else begin
      mem_rd_valid <= 1'b0;
      mem_collide  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (mem_wr_req) begin
            state       <= ST_WR_SETUP;
            sram_addr   <= mem_addr;
            sram_dq_out <= mem_wr_data;
            sram_dq_oe  <= 1'b1;
            sram_ce_n   <= 1'b0;
            mem_busy    <= 1'b1;
            mem_collide <= mem_rd_req;
          end else if (mem_rd_req) begin
            sram_addr <= mem_addr;
            sram_ce_n <= 1'b0;
            mem_busy  <= 1'b1;
            if (use_turn) begin
              state <= ST_RD_TURN;
            end else begin
              state     <= ST_RD_STROBE;
              sram_oe_n <= 1'b0;
            end
          end
        end
        ST_WR_SETUP: begin
          state     <= ST_WR_PULSE;
          sram_we_n <= 1'b0;
        end
        ST_WR_PULSE: begin
          if (cnt_zero) begin
            state     <= ST_WR_HOLD;
            sram_we_n <= 1'b1;
          end
        end
        ST_WR_HOLD: begin
          state      <= ST_IDLE;
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          mem_busy   <= 1'b0;
          last_wr    <= 1'b1;
        end
        ST_RD_TURN: begin
          if (cnt_zero) begin
            state     <= ST_RD_STROBE;
            sram_oe_n <= 1'b0;
          end
        end
        ST_RD_STROBE: begin
          if (cnt_zero) begin
            state        <= ST_IDLE;
            mem_rd_data  <= sram_dq_in;
            mem_rd_valid <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_ce_n    <= 1'b1;
            mem_busy     <= 1'b0;
            last_wr      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a behavioural async SRAM model.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd_req = 1'b0;
  logic        mem_wr_req = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wr_data = '0;
  logic        mem_busy;
  logic [15:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_collide;
  logic [15:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n;
  logic        sram_we_n;
  logic        sram_oe_n;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];

  // Running totals maintained only by the monitor.
  int n_we = 0, n_oe = 0, n_busy = 0, n_valid = 0, n_coll = 0, n_turn = 0, n_clash = 0;
  logic [15:0] valid_data = '0;

  // Per-operation deltas.
  int d_we, d_oe, d_busy, d_valid, d_coll, d_turn;

  always #5 clk = ~clk;

  sram_responder dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_req   (mem_wr_req),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_busy     (mem_busy),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_collide  (mem_collide),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_oe   (sram_dq_oe),
    .sram_dq_in   (sram_dq_in),
    .sram_ce_n    (sram_ce_n),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n)
  );

  // Async SRAM: drives data while selected and output-enabled, stores on strobe.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq_out;
  end

  // Cycle monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_we_n) n_we++;
      if (!sram_oe_n) n_oe++;
      if (mem_busy) n_busy++;
      if (mem_rd_valid) begin
        n_valid++;
        valid_data = mem_rd_data;
      end
      if (mem_collide) n_coll++;
      if (!sram_ce_n && sram_oe_n && sram_we_n && !sram_dq_oe) n_turn++;
      if (sram_dq_oe && !sram_oe_n) n_clash++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request (called just after a falling edge) and run it to completion.
  task automatic op(input logic rd, input logic wr, input logic [15:0] addr,
                    input logic [15:0] data);
    int s_we, s_oe, s_busy, s_valid, s_coll, s_turn;
    bit done;
    s_we = n_we; s_oe = n_oe; s_busy = n_busy;
    s_valid = n_valid; s_coll = n_coll; s_turn = n_turn;
    mem_rd_req = rd; mem_wr_req = wr; mem_addr = addr; mem_wr_data = data;
    @(posedge clk); #1;
    mem_rd_req = 1'b0; mem_wr_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (!mem_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("op_timeout", 32'd1, 32'd0);
    d_we = n_we - s_we; d_oe = n_oe - s_oe; d_busy = n_busy - s_busy;
    d_valid = n_valid - s_valid; d_coll = n_coll - s_coll; d_turn = n_turn - s_turn;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0011] = 16'hA5C3;
    mem[16'h0030] = 16'h0BEE;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_ctl", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'd7);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_rd_data", 32'(mem_rd_data), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Write 0x0010 <- 1111.
    op(1'b0, 1'b1, 16'h0010, 16'h1111);
    chk("wr_we_cycles", 32'(d_we), 32'd2);
    chk("wr_busy_cycles", 32'(d_busy), 32'd4);
    chk("wr_no_valid", 32'(d_valid), 32'd0);
    chk("wr_mem", 32'(mem[16'h0010]), 32'h1111);

    // Read right after the write: one turnaround cycle. Returns on the valid cycle.
    op(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd1_turn", 32'(d_turn), 32'd1);
    chk("rd1_oe_cycles", 32'(d_oe), 32'd2);
    chk("rd1_busy", 32'(d_busy), 32'd3);
    chk("rd1_valid", 32'(d_valid), 32'd1);
    chk("rd1_data", 32'(valid_data), 32'h1111);

    // Back-to-back reads, issued in the valid cycle of the previous one.
    op(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd2_turn", 32'(d_turn), 32'd0);
    chk("rd2_busy", 32'(d_busy), 32'd2);
    chk("rd2_data", 32'(valid_data), 32'h1111);
    op(1'b1, 1'b0, 16'h0011, 16'h0000);
    chk("rd3_valid", 32'(d_valid), 32'd1);
    chk("rd3_data", 32'(mem_rd_data), 32'hA5C3);

    // Simultaneous read and write: write wins, collide pulses.
    op(1'b1, 1'b1, 16'h0020, 16'h2222);
    chk("coll_pulse", 32'(d_coll), 32'd1);
    chk("coll_no_valid", 32'(d_valid), 32'd0);
    chk("coll_busy", 32'(d_busy), 32'd4);
    chk("coll_mem", 32'(mem[16'h0020]), 32'h2222);
    chk("coll_rd_hold", 32'(mem_rd_data), 32'hA5C3);

    // Reset in the middle of the write strobe.
    @(negedge clk); #1;
    mem_wr_req = 1'b1; mem_addr = 16'h0040; mem_wr_data = 16'h4444;
    @(posedge clk); #1;
    mem_wr_req = 1'b0;
    @(posedge clk); #1;
    chk("mid_we_low", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(mem_busy), 32'd0);
    chk("mid_rst_ctl", {28'd0, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n}, 32'd7);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    chk("mid_rst_rd_data", 32'(mem_rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    op(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("post_rst_turn", 32'(d_turn), 32'd0);
    chk("post_rst_data", 32'(valid_data), 32'h1111);

    // Request while busy is ignored.
    @(negedge clk); #1;
    mem_wr_req = 1'b1; mem_addr = 16'h0050; mem_wr_data = 16'h5555;
    @(posedge clk); #1;
    mem_wr_req = 1'b0;
    @(negedge clk); #1;
    mem_wr_req = 1'b1; mem_addr = 16'h0030; mem_wr_data = 16'h3333;
    @(posedge clk); #1;
    mem_wr_req = 1'b0;
    for (int i = 0; i < 20 && mem_busy; i++) begin
      @(negedge clk); #1;
    end
    chk("busy_ign_idle", 32'(mem_busy), 32'd0);
    chk("busy_ign_wr_ok", 32'(mem[16'h0050]), 32'h5555);
    chk("busy_ign_mem", 32'(mem[16'h0030]), 32'h0BEE);
    @(negedge clk); #1;
    op(1'b1, 1'b0, 16'h0030, 16'h0000);
    chk("busy_ign_rd", 32'(valid_data), 32'h0BEE);
    chk("busy_ign_turn", 32'(d_turn), 32'd1);

    chk("no_contention", 32'(n_clash), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
